// File: rtl/shift_normalizer32.sv
// rtl/shift_normalizer32.sv - sequential normalizer: strips leading or trailing zeros one bit per cycle
module shift_normalizer32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] D,
  input  logic             DIR,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] SHAMT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             dir;
  logic             target_bit;

  // Bit that must be set for the working value to count as normalized.
  assign target_bit = dir ? sreg[WIDTH-1] : sreg[0];
  assign BUSY       = (state == SHIFT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      Y     <= '0;
      SHAMT <= '0;
      ZERO  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (D == '0) begin
              // An all-zero operand never normalizes; report it without entering SHIFT.
              Y     <= '0;
              SHAMT <= CNT_W'(WIDTH);
              ZERO  <= 1'b1;
              DONE  <= 1'b1;
            end else begin
              sreg  <= D;
              cnt   <= '0;
              dir   <= DIR;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (target_bit) begin
            Y     <= sreg;
            SHAMT <= cnt;
            ZERO  <= 1'b0;
            DONE  <= 1'b1;
            state <= IDLE;
          end else begin
            sreg <= dir ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            cnt  <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_normalizer32.sv
// tb/tb_shift_normalizer32.sv - self-checking bench for shift_normalizer32
module tb_shift_normalizer32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] D;
  logic        DIR;
  logic [31:0] Y;
  logic [5:0]  SHAMT;
  logic        ZERO;
  logic        BUSY;
  logic        DONE;

  shift_normalizer32 dut (
    .CLK(CLK), .RST(RST), .START(START), .D(D), .DIR(DIR),
    .Y(Y), .SHAMT(SHAMT), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d;
    logic        dir;
    logic [31:0] y;
    logic [5:0]  shamt;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic [5:0]  shamt;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Latency counts edges after the accepting edge: zero operand completes on it, else n+1 later.
  task automatic push_exp(input logic [31:0] y, input logic [5:0] shamt, input logic zero);
    exp_t e;
    e.y = y; e.shamt = shamt; e.zero = zero;
    e.lat = zero ? 0 : int'(shamt) + 1;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] d, input logic dir);
    START = 1'b1; D = d; DIR = dir;
    tick();
    START = 1'b0;
  endtask

  task automatic collect(input int lat_start, input bit post);
    int   lat;
    exp_t e;
    lat = lat_start;
    while (DONE !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got DONE expected none");
      return;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("y", Y, e.y);
    check("shamt", {26'd0, SHAMT}, {26'd0, e.shamt});
    check("zero", {31'd0, ZERO}, {31'd0, e.zero});
    if (post) begin
      tick();
      check("done_pulse", {31'd0, DONE}, 32'd0);
      check("y_hold", Y, e.y);
    end
  endtask

  task automatic run_op(input vec_t v);
    push_exp(v.y, v.shamt, v.zero);
    issue(v.d, v.dir);
    check("busy_after_accept", {31'd0, BUSY}, {31'd0, ~v.zero});
    collect(0, 1'b1);
  endtask

  vec_t vecs[12];
  int   done_seen;

  initial begin
    vecs[0]  = '{32'h0000_0001, 1'b1, 32'h8000_0000, 6'd31, 1'b0};
    vecs[1]  = '{32'h8000_0000, 1'b1, 32'h8000_0000, 6'd0,  1'b0};
    vecs[2]  = '{32'h0000_0003, 1'b0, 32'h0000_0003, 6'd0,  1'b0};
    vecs[3]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 6'd32, 1'b1};
    vecs[4]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1};
    vecs[5]  = '{32'h00F0_0000, 1'b0, 32'h0000_000F, 6'd20, 1'b0};
    vecs[6]  = '{32'h00F0_0000, 1'b1, 32'hF000_0000, 6'd8,  1'b0};
    vecs[7]  = '{32'h8000_0000, 1'b0, 32'h0000_0001, 6'd31, 1'b0};
    vecs[8]  = '{32'h1234_5678, 1'b1, 32'h91A2_B3C0, 6'd3,  1'b0};
    vecs[9]  = '{32'h1234_5678, 1'b0, 32'h0246_8ACF, 6'd3,  1'b0};
    vecs[10] = '{32'h4000_0000, 1'b1, 32'h8000_0000, 6'd1,  1'b0};
    vecs[11] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 6'd0,  1'b0};

    RST = 1'b1; START = 1'b0; D = '0; DIR = 1'b0;
    tick(); tick();
    RST = 1'b0;
    check("rst_y", Y, 32'd0);
    check("rst_shamt", {26'd0, SHAMT}, 32'd0);
    check("rst_flags", {29'd0, ZERO, BUSY, DONE}, 32'd0);

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // START while busy with a different operand must be ignored.
    push_exp(32'h8000_0000, 6'd31, 1'b0);
    issue(32'h0000_0001, 1'b1);
    tick(); tick();
    START = 1'b1; D = 32'hFFFF_FFFF; DIR = 1'b0;
    tick();
    START = 1'b0;
    check("busy_ignore", {31'd0, BUSY}, 32'd1);
    collect(3, 1'b1);

    // Back-to-back: new START raised in the DONE cycle is accepted on its closing edge.
    push_exp(32'h8000_0000, 6'd2, 1'b0);
    issue(32'h2000_0000, 1'b1);
    collect(0, 1'b0);
    push_exp(32'h8000_0000, 6'd1, 1'b0);
    issue(32'h4000_0000, 1'b1);
    check("b2b_busy", {31'd0, BUSY}, 32'd1);
    check("b2b_done_low", {31'd0, DONE}, 32'd0);
    collect(0, 1'b1);

    // Reset mid-operation aborts with no DONE.
    issue(32'h0000_0001, 1'b1);
    repeat (9) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_y", Y, 32'd0);
    check("abort_shamt", {26'd0, SHAMT}, 32'd0);
    check("abort_flags", {29'd0, ZERO, BUSY, DONE}, 32'd0);
    done_seen = 0;
    repeat (40) begin
      tick();
      if (DONE === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);

    run_op('{32'h0000_0100, 1'b0, 32'h0000_0001, 6'd8, 1'b0});
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
